alu_control_seq: RTL and testbench
==================================

Name: alu_control_seq

Overview:
Parametrised successor to the single-cycle ALU control decoder. Registers the incoming funct code and fans it out to the ALU, shifter, multiplier and result MUX. Sequences multi-cycle MULTU (and optionally DIVU) through an explicit FSM with a cycle counter, a busy/ready handshake and a one-cycle HiLo open/write strobe. Sits between the ID/EX funct field and the EX-stage datapath units.

Parameters:
FUNCT_W, 6, width of the funct code and of every control output
MUL_CYCLES, 32, cycles the multiplier is held in MULTU before HiLo open (>=1)
DIV_CYCLES, 32, cycles the divider is held in DIVU before HiLo open (>=1)
CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES)
NOP_CODE, 6'b000000, control value driven after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
funct_in  in  FUNCT_W  operation code (AND 36, OR 37, ADD 32, SUB 34, SLT 42, SLL 0, MULTU 25, DIVU 27)
op_valid  in  1  funct_in valid this cycle
op_ready  out  1  block can accept an op (= !busy)
busy  out  1  multi-cycle op in progress
ctrl_alu  out  FUNCT_W  control to ALU
ctrl_sht  out  FUNCT_W  control to shifter
ctrl_mul  out  FUNCT_W  control to multiplier/divider
ctrl_mux  out  FUNCT_W  control to result MUX
hilo_we  out  1  one-cycle HiLo open/write strobe
cycle_cnt  out  CNT_W  current multi-cycle count (0 when idle)

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset, including mid-operation: state IDLE, all ctrl_* = NOP_CODE, cycle_cnt = 0, busy = 0, hilo_we = 0. An aborted op produces no hilo_we.
- All outputs are registered. The four ctrl_* outputs always carry the same value.
- Accept = op_valid && op_ready, sampled at the rising edge. Latency is 1 cycle: ctrl_* shows the accepted funct in the following cycle.
- op_valid while busy is ignored and not queued.
- IDLE:
  - Accept of a single-cycle funct: ctrl_* <= funct_in; stay IDLE.
  - Unknown codes pass through unchanged.
  - No accept: ctrl_* hold their previous value.
- IDLE, accept of MULTU: ctrl_* <= 25, cycle_cnt <= 1, busy <= 1, go to MUL.
- MUL:
  - Each edge with cycle_cnt < MUL_CYCLES: cycle_cnt++.
  - Edge with cycle_cnt == MUL_CYCLES: ctrl_* <= 6'b111111 (HILO_OPEN), hilo_we <= 1, cycle_cnt <= 0, go to WB.
  - Net effect: MULTU is visible for exactly MUL_CYCLES cycles.
- DIV: identical to MUL, using code 27 and DIV_CYCLES.
- WB: lasts exactly one cycle, busy = 1. Next edge: hilo_we <= 0, ctrl_* <= NOP_CODE, busy <= 0, go to IDLE.
- The first new op can be accepted in the cycle after WB.
- MUL_CYCLES = 1: MULTU visible 1 cycle, then WB.
- cycle_cnt never wraps, given the CNT_W constraint. An elaboration-time check fails if the constraint is violated.
- Unreachable state encodings return to IDLE with reset values.

Optional Feature:
ALU_CTRL_DIVU_EN
- Defined: DIVU (27) takes the DIV state path described above.
- Undefined: the DIV state and DIV_CYCLES logic are not compiled. Code 27 is treated as a single-cycle pass-through: no busy, no hilo_we.

Decomposition:
- Package alu_ctrl_pkg holds:
  - funct constants: F_AND=36, F_OR=37, F_ADD=32, F_SUB=34, F_SLT=42, F_SLL=0, F_MULTU=25, F_DIVU=27, HILO_OPEN=6'b111111
  - state typedef {IDLE, MUL, DIV, WB}
- One sub-module, alu_ctrl_counter: CNT_W-wide counter with sync clear, enable and terminal-count compare against a runtime limit.
- The FSM and output registers live in the top module.

Test Plan:
- rst for 2 cycles, then idle -> ctrl_*=0, busy=0, hilo_we=0, cycle_cnt=0.
- Accept ADD(32), then SUB(34) on consecutive cycles -> ctrl_* = 32, then 34, each 1 cycle after accept; busy stays 0.
- Accept MULTU with MUL_CYCLES=32 -> ctrl_*=25 for 32 cycles with cycle_cnt 1..32; then ctrl_*=63 with hilo_we=1 for 1 cycle; then ctrl_*=0, busy=0. AND issued during busy is ignored.
- MULTU, rst asserted at cycle_cnt=10 -> next edge: ctrl_*=0, cycle_cnt=0, busy=0; no hilo_we pulse ever.
- With ALU_CTRL_DIVU_EN and DIV_CYCLES=4: DIVU -> ctrl_*=27 for 4 cycles, then hilo_we for 1 cycle. Without the macro: DIVU -> ctrl_*=27, busy=0.
- MUL_CYCLES=1: MULTU -> 1 cycle of 25, 1 cycle of 63 with hilo_we; op_ready reasserts 2 cycles after accept.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: funct codes and FSM state type shared by the ALU control sequencer.
package alu_ctrl_pkg;
    localparam logic [5:0] F_AND     = 6'd36;
    localparam logic [5:0] F_OR      = 6'd37;
    localparam logic [5:0] F_ADD     = 6'd32;
    localparam logic [5:0] F_SUB     = 6'd34;
    localparam logic [5:0] F_SLT     = 6'd42;
    localparam logic [5:0] F_SLL     = 6'd0;
    localparam logic [5:0] F_MULTU   = 6'd25;
    localparam logic [5:0] F_DIVU    = 6'd27;
    localparam logic [5:0] HILO_OPEN = 6'b111111;
    typedef enum logic [1:0] {IDLE, MUL, DIV, WB} state_t;
endpackage

// File: rtl/alu_ctrl_counter.sv
// alu_ctrl_counter: cycle counter with sync clear, enable and terminal-count compare.
module alu_ctrl_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt_q <= '0;
        else if (en)    cnt_q <= cnt_q + 1'b1;
    end
    assign cnt = cnt_q;
    assign tc  = (cnt_q == limit);
endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered funct fan-out with MULTU (and, with ALU_CTRL_DIVU_EN, DIVU) sequencing.
// Multi-cycle ops hold their code for N cycles, then emit one HILO_OPEN/hilo_we cycle.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int                 FUNCT_W    = 6,
    parameter int                 MUL_CYCLES = 32,
    parameter int                 DIV_CYCLES = 32,
    parameter int                 CNT_W      = 6,
    parameter logic [FUNCT_W-1:0] NOP_CODE   = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FUNCT_W-1:0] funct_in,
    input  logic               op_valid,
    output logic               op_ready,
    output logic               busy,
    output logic [FUNCT_W-1:0] ctrl_alu,
    output logic [FUNCT_W-1:0] ctrl_sht,
    output logic [FUNCT_W-1:0] ctrl_mul,
    output logic [FUNCT_W-1:0] ctrl_mux,
    output logic               hilo_we,
    output logic [CNT_W-1:0]   cycle_cnt
);
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;

    generate
        if ((2 ** CNT_W) <= MAX_CYC || MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_cfg
            $error("alu_control_seq: CNT_W too small or cycle count below 1");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [FUNCT_W-1:0] ctrl_q, ctrl_d;
    logic               busy_q, busy_d;
    logic               hilo_q, hilo_d;
    logic               cnt_en, cnt_clr, cnt_tc;
    logic [CNT_W-1:0]   cnt_lim;
    logic               accept;

    assign accept = op_valid && !busy_q;
`ifdef ALU_CTRL_DIVU_EN
    assign cnt_lim = (state_q == DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
`else
    assign cnt_lim = CNT_W'(MUL_CYCLES);
`endif

    alu_ctrl_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cnt_lim),
        .cnt   (cycle_cnt),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        busy_d  = busy_q;
        hilo_d  = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                ctrl_d = funct_in;
                if (funct_in == FUNCT_W'(F_MULTU)) begin
                    state_d = MUL;
                    busy_d  = 1'b1;
                    cnt_en  = 1'b1;
                end
`ifdef ALU_CTRL_DIVU_EN
                else if (funct_in == FUNCT_W'(F_DIVU)) begin
                    state_d = DIV;
                    busy_d  = 1'b1;
                    cnt_en  = 1'b1;
                end
`endif
            end
`ifdef ALU_CTRL_DIVU_EN
            MUL, DIV: begin
`else
            MUL: begin
`endif
                ctrl_d  = cnt_tc ? FUNCT_W'(HILO_OPEN) : ctrl_q;
                hilo_d  = cnt_tc;
                cnt_clr = cnt_tc;
                cnt_en  = !cnt_tc;
                state_d = cnt_tc ? WB : state_q;
            end
            WB: begin
                state_d = IDLE;
                ctrl_d  = NOP_CODE;
                busy_d  = 1'b0;
            end
            // Unreachable encodings (DIV when disabled) recover to reset values
            default: begin
                state_d = IDLE;
                ctrl_d  = NOP_CODE;
                busy_d  = 1'b0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctrl_q  <= NOP_CODE;
            busy_q  <= 1'b0;
            hilo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
            hilo_q  <= hilo_d;
        end
    end

    assign op_ready = !busy_q;
    assign busy     = busy_q;
    assign hilo_we  = hilo_q;
    assign ctrl_alu = ctrl_q;
    assign ctrl_sht = ctrl_q;
    assign ctrl_mul = ctrl_q;
    assign ctrl_mux = ctrl_q;
endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: two configurations (MUL 32/DIV 32 and MUL 1/DIV 4) against a schedule-based model.
module tb_alu_control_seq;
    typedef struct packed {
        logic [5:0] ctrl;
        logic       busy;
        logic       we;
        logic [5:0] cnt;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic [5:0] funct = 6'd0;

    logic       rdy_o [2];
    logic       busy_o [2];
    logic       we_o [2];
    logic [5:0] alu_o [2];
    logic [5:0] sht_o [2];
    logic [5:0] mul_o [2];
    logic [5:0] mux_o [2];
    logic [5:0] cnt_o [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_control_seq #(.MUL_CYCLES(32), .DIV_CYCLES(32)) u0 (
        .clk(clk), .rst(rst), .funct_in(funct), .op_valid(op_valid),
        .op_ready(rdy_o[0]), .busy(busy_o[0]),
        .ctrl_alu(alu_o[0]), .ctrl_sht(sht_o[0]), .ctrl_mul(mul_o[0]), .ctrl_mux(mux_o[0]),
        .hilo_we(we_o[0]), .cycle_cnt(cnt_o[0])
    );

    alu_control_seq #(.MUL_CYCLES(1), .DIV_CYCLES(4)) u1 (
        .clk(clk), .rst(rst), .funct_in(funct), .op_valid(op_valid),
        .op_ready(rdy_o[1]), .busy(busy_o[1]),
        .ctrl_alu(alu_o[1]), .ctrl_sht(sht_o[1]), .ctrl_mul(mul_o[1]), .ctrl_mux(mux_o[1]),
        .hilo_we(we_o[1]), .cycle_cnt(cnt_o[1])
    );

    // Model: a multi-cycle accept writes the whole future output sequence into a schedule
    int   mul_n [2] = '{32, 1};
    int   div_n [2] = '{32, 4};
    out_t cur [2];
    out_t sched [2][0:40];
    int   sidx [2] = '{0, 0};
    int   slen [2] = '{0, 0};
`ifdef ALU_CTRL_DIVU_EN
    localparam bit DIVU_EN = 1'b1;
`else
    localparam bit DIVU_EN = 1'b0;
`endif

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                cur[i]  = '{6'd0, 1'b0, 1'b0, 6'd0};
                sidx[i] = 0;
                slen[i] = 0;
            end else if (sidx[i] < slen[i]) begin
                cur[i]  = sched[i][sidx[i]];
                sidx[i] = sidx[i] + 1;
            end else if (op_valid && !cur[i].busy) begin
                int n;
                n = (funct == 6'd25) ? mul_n[i] : (DIVU_EN && funct == 6'd27) ? div_n[i] : 0;
                if (n == 0) begin
                    cur[i].ctrl = funct;
                end else begin
                    for (int k = 0; k < n; k++) sched[i][k] = '{funct, 1'b1, 1'b0, 6'(k + 1)};
                    sched[i][n]     = '{6'd63, 1'b1, 1'b1, 6'd0};
                    sched[i][n + 1] = '{6'd0, 1'b0, 1'b0, 6'd0};
                    slen[i] = n + 2;
                    cur[i]  = sched[i][0];
                    sidx[i] = 1;
                end
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.ctrl_alu", i), int'(alu_o[i]), int'(cur[i].ctrl));
            check($sformatf("u%0d.ctrl_sht", i), int'(sht_o[i]), int'(cur[i].ctrl));
            check($sformatf("u%0d.ctrl_mul", i), int'(mul_o[i]), int'(cur[i].ctrl));
            check($sformatf("u%0d.ctrl_mux", i), int'(mux_o[i]), int'(cur[i].ctrl));
            check($sformatf("u%0d.busy", i), int'(busy_o[i]), int'(cur[i].busy));
            check($sformatf("u%0d.op_ready", i), int'(rdy_o[i]), int'(!cur[i].busy));
            check($sformatf("u%0d.hilo_we", i), int'(we_o[i]), int'(cur[i].we));
            check($sformatf("u%0d.cycle_cnt", i), int'(cnt_o[i]), int'(cur[i].cnt));
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [5:0] f);
        rst      = r;
        op_valid = v;
        funct    = f;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 6'd0);
    endtask

    logic [5:0] pool [12] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0,
                              6'd25, 6'd27, 6'd13, 6'd32, 6'd36, 6'd42};

    initial begin
        @(negedge clk);
        cyc(1'b1, 1'b0, 6'd0);
        cyc(1'b1, 1'b1, 6'd32);
        idle(3);
        cyc(1'b0, 1'b1, 6'd32);
        cyc(1'b0, 1'b1, 6'd34);
        idle(2);
        cyc(1'b0, 1'b1, 6'd25);
        cyc(1'b0, 1'b1, 6'd36);
        idle(36);
        cyc(1'b0, 1'b1, 6'd25);
        idle(9);
        cyc(1'b1, 1'b0, 6'd0);
        idle(40);
        cyc(1'b0, 1'b1, 6'd27);
        idle(40);
        cyc(1'b0, 1'b1, 6'd63);
        idle(2);
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) != 0), pool[$urandom_range(0, 11)]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
